lut_rr_arbiter: RTL and testbench

Shares the single combinational read port of the 32x8 constant LUT (mem_LUT) among NUM_REQ requesters, e.g. fetch, ALU-immediate and load-constant paths. Round-robin arbitration picks one requester per cycle and drives the LUT address. The LUT data is captured into a per-requester response register, which is held under a valid/ready handshake until consumed.

---
 rtl/lut_rr_arbiter.sv | 94 +++++++++
 tb/tb_lut_rr_arbiter.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lut_rr_arbiter.sv
// Round-robin arbiter sharing one combinational LUT read port among NUM_REQ requesters.
// Each grant captures the LUT data into a per-requester response register held under valid/ready.
module lut_rr_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 5,
    parameter int unsigned DATA_W  = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        stall,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
    output logic [NUM_REQ-1:0]          gnt,
    output logic [ADDR_W-1:0]           lut_addr,
    input  logic [DATA_W-1:0]           lut_data,
    output logic [NUM_REQ-1:0]          rsp_valid,
    input  logic [NUM_REQ-1:0]          rsp_ready,
    output logic [NUM_REQ*DATA_W-1:0]   rsp_data,
    output logic                        idle
);

    localparam int unsigned PtrW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0] pend_q, pend_d;
    logic [DATA_W-1:0]  rsp_q [NUM_REQ];
    logic [PtrW-1:0]    ptr_q, ptr_d;

    logic [NUM_REQ-1:0] elig;
    logic               grant;
    logic [PtrW-1:0]    winner;

    // Only the registered pend feeds eligibility, so rsp_ready never reaches gnt combinationally.
    assign elig = req & ~pend_q;

    always_comb begin : arb_scan
        int unsigned idx;
        idx    = 0;
        grant  = 1'b0;
        winner = '0;
        if (!reset && !stall) begin
            for (int unsigned k = 0; k < NUM_REQ; k++) begin
                idx = (32'(ptr_q) + k) % NUM_REQ;
                if (!grant && elig[PtrW'(idx)]) begin
                    grant  = 1'b1;
                    winner = PtrW'(idx);
                end
            end
        end
    end

    always_comb begin
        gnt      = '0;
        lut_addr = '0;
        if (grant) begin
            gnt[winner] = 1'b1;
            lut_addr    = req_addr[32'(winner)*ADDR_W +: ADDR_W];
        end
    end

    always_comb begin
        pend_d = (pend_q & ~rsp_ready) | gnt;
        ptr_d  = ptr_q;
        if (grant) begin
            ptr_d = PtrW'((32'(winner) + 32'd1) % NUM_REQ);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            ptr_q  <= '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                rsp_q[i] <= '0;
            end
        end else begin
            pend_q <= pend_d;
            ptr_q  <= ptr_d;
            if (grant) begin
                rsp_q[winner] <= lut_data;
            end
        end
    end

    always_comb begin
        rsp_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            rsp_data[i*DATA_W +: DATA_W] = rsp_q[i];
        end
    end

    assign rsp_valid = pend_q;
    assign idle      = reset | (~|req & ~|pend_q);

endmodule

// File: tb/tb_lut_rr_arbiter.sv
// Directed self-checking bench for lut_rr_arbiter with a behavioural mem_LUT model.
module tb_lut_rr_arbiter;

    logic        clk;
    logic        reset;
    logic        stall;
    logic [3:0]  req;
    logic [19:0] req_addr;
    logic [3:0]  gnt;
    logic [4:0]  lut_addr;
    logic [7:0]  lut_data;
    logic [3:0]  rsp_valid;
    logic [3:0]  rsp_ready;
    logic [31:0] rsp_data;
    logic        idle;

    int errors = 0;
    int checks = 0;

    lut_rr_arbiter #(
        .NUM_REQ(4),
        .ADDR_W (5),
        .DATA_W (8)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .req      (req),
        .req_addr (req_addr),
        .gnt      (gnt),
        .lut_addr (lut_addr),
        .lut_data (lut_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .idle     (idle)
    );

    // Entries 0..15 hold 60+addr; upper entries get an arbitrary pattern.
    function automatic logic [7:0] lut_val(input logic [4:0] a);
        if (a < 5'd16) return 8'd60 + {3'b000, a};
        return 8'hA0 ^ {3'b000, a};
    endfunction

    assign lut_data = lut_val(lut_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int i, input logic [4:0] a);
        req_addr[i*5 +: 5] = a;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        stall     = 1'b0;
        req       = 4'b0000;
        rsp_ready = 4'b0000;
        req_addr  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        reset = 1'b1;
        req   = 4'b1111;
        #1;
        checks++;
        if (gnt !== 4'b0000) begin
            errors++;
            $display("FAIL reset_gnt: got %b expected %b", gnt, 4'b0000);
        end
        checks++;
        if (lut_addr !== 5'd0) begin
            errors++;
            $display("FAIL reset_lut_addr: got %0d expected 0", lut_addr);
        end
        checks++;
        if (rsp_valid !== 4'b0000 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL reset_rsp: got valid=%b data=%h expected 0/0", rsp_valid, rsp_data);
        end
        checks++;
        if (idle !== 1'b1) begin
            errors++;
            $display("FAIL reset_idle: got %b expected 1", idle);
        end
        req = 4'b0000;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        set_addr(0, 5'd3);
        req = 4'b0001;
        #1;
        checks++;
        if (gnt !== 4'b0001 || lut_addr !== 5'd3) begin
            errors++;
            $display("FAIL single_grant: got gnt=%b addr=%0d expected 0001/3", gnt, lut_addr);
        end
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if (rsp_valid !== 4'b0001 || rsp_data[7:0] !== 8'd63) begin
            errors++;
            $display("FAIL single_rsp: got valid=%b data=%0d expected 0001/63",
                     rsp_valid, rsp_data[7:0]);
        end
        rsp_ready = 4'b0001;
        tick();
        checks++;
        if (rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL single_consume: got valid=%b expected 0000", rsp_valid);
        end
        rsp_ready = 4'b0000;
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_gnt  [5] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        logic [4:0] exp_addr [5] = '{5'd0, 5'd5, 5'd10, 5'd15, 5'd0};
        logic [7:0] exp_data [5] = '{8'd60, 8'd65, 8'd70, 8'd75, 8'd60};
        int         widx     [5] = '{0, 1, 2, 3, 0};
        do_reset();
        set_addr(0, 5'd0);
        set_addr(1, 5'd5);
        set_addr(2, 5'd10);
        set_addr(3, 5'd15);
        req       = 4'b1111;
        rsp_ready = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++;
            if (gnt !== exp_gnt[k] || lut_addr !== exp_addr[k]) begin
                errors++;
                $display("FAIL rr_grant[%0d]: got gnt=%b addr=%0d expected %b/%0d",
                         k, gnt, lut_addr, exp_gnt[k], exp_addr[k]);
            end
            tick();
            checks++;
            if (rsp_valid !== exp_gnt[k] || rsp_data[widx[k]*8 +: 8] !== exp_data[k]) begin
                errors++;
                $display("FAIL rr_rsp[%0d]: got valid=%b data=%0d expected %b/%0d",
                         k, rsp_valid, rsp_data[widx[k]*8 +: 8], exp_gnt[k], exp_data[k]);
            end
        end
        req = 4'b0000;
        tick();
        rsp_ready = 4'b0000;
    endtask

    task automatic test_backpressure();
        logic [3:0] exp;
        do_reset();
        set_addr(0, 5'd0);
        set_addr(1, 5'd7);
        req       = 4'b0011;
        rsp_ready = 4'b0010;
        #1;
        checks++;
        if (gnt !== 4'b0001) begin
            errors++;
            $display("FAIL bp_first: got gnt=%b expected 0001", gnt);
        end
        tick();
        for (int k = 1; k <= 6; k++) begin
            exp = (k % 2 == 1) ? 4'b0010 : 4'b0000;
            if (k == 6) rsp_ready = 4'b0011;
            #1;
            checks++;
            if (gnt !== exp || rsp_valid[0] !== 1'b1 || rsp_data[7:0] !== 8'd60) begin
                errors++;
                $display("FAIL bp_cycle[%0d]: got gnt=%b v0=%b d0=%0d expected %b/1/60",
                         k, gnt, rsp_valid[0], rsp_data[7:0], exp);
            end
            tick();
        end
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || gnt !== 4'b0001 || lut_addr !== 5'd0) begin
            errors++;
            $display("FAIL bp_release: got valid=%b gnt=%b addr=%0d expected 0000/0001/0",
                     rsp_valid, gnt, lut_addr);
        end
        req = 4'b0000;
        tick();
        tick();
        rsp_ready = 4'b0000;
    endtask

    task automatic test_stall();
        do_reset();
        set_addr(1, 5'd9);
        stall = 1'b1;
        req   = 4'b0010;
        for (int k = 0; k < 3; k++) begin
            #1;
            checks++;
            if (gnt !== 4'b0000 || lut_addr !== 5'd0 || rsp_valid !== 4'b0000) begin
                errors++;
                $display("FAIL stall[%0d]: got gnt=%b addr=%0d valid=%b expected 0000/0/0000",
                         k, gnt, lut_addr, rsp_valid);
            end
            tick();
        end
        stall = 1'b0;
        #1;
        checks++;
        if (gnt !== 4'b0010 || lut_addr !== 5'd9) begin
            errors++;
            $display("FAIL stall_release: got gnt=%b addr=%0d expected 0010/9", gnt, lut_addr);
        end
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if (rsp_valid !== 4'b0010 || rsp_data[15:8] !== 8'd69) begin
            errors++;
            $display("FAIL stall_rsp: got valid=%b data=%0d expected 0010/69",
                     rsp_valid, rsp_data[15:8]);
        end
        rsp_ready = 4'b0010;
        tick();
        rsp_ready = 4'b0000;
    endtask

    task automatic test_async_reset();
        do_reset();
        set_addr(1, 5'd4);
        set_addr(3, 5'd20);
        req = 4'b1000;
        tick();
        req = 4'b0010;
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if (rsp_valid !== 4'b1010 || idle !== 1'b0) begin
            errors++;
            $display("FAIL ar_setup: got valid=%b idle=%b expected 1010/0", rsp_valid, idle);
        end
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (rsp_valid !== 4'b0000 || idle !== 1'b1 || rsp_data !== 32'd0) begin
            errors++;
            $display("FAIL ar_immediate: got valid=%b idle=%b data=%h expected 0000/1/0",
                     rsp_valid, idle, rsp_data);
        end
        tick();
        reset = 1'b0;
        req   = 4'b1000;
        #1;
        checks++;
        if (gnt !== 4'b1000 || lut_addr !== 5'd20) begin
            errors++;
            $display("FAIL ar_regrant: got gnt=%b addr=%0d expected 1000/20", gnt, lut_addr);
        end
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if (rsp_valid !== 4'b1000 || rsp_data[31:24] !== 8'hB4) begin
            errors++;
            $display("FAIL ar_upper_data: got valid=%b data=%h expected 1000/b4",
                     rsp_valid, rsp_data[31:24]);
        end
        rsp_ready = 4'b1000;
        tick();
        rsp_ready = 4'b0000;
    endtask

    task automatic test_idle();
        do_reset();
        set_addr(2, 5'd1);
        req = 4'b0100;
        #1;
        checks++;
        if (idle !== 1'b0) begin
            errors++;
            $display("FAIL idle_req: got %b expected 0", idle);
        end
        tick();
        req = 4'b0000;
        #1;
        checks++;
        if (idle !== 1'b0 || rsp_valid !== 4'b0100) begin
            errors++;
            $display("FAIL idle_pend: got idle=%b valid=%b expected 0/0100", idle, rsp_valid);
        end
        rsp_ready = 4'b1111;
        tick();
        checks++;
        if (idle !== 1'b1 || gnt !== 4'b0000 || lut_addr !== 5'd0 || rsp_valid !== 4'b0000) begin
            errors++;
            $display("FAIL idle_done: got idle=%b gnt=%b addr=%0d valid=%b expected 1/0000/0/0000",
                     idle, gnt, lut_addr, rsp_valid);
        end
        rsp_ready = 4'b0000;
    endtask

    initial begin
        reset     = 1'b1;
        stall     = 1'b0;
        req       = 4'b0000;
        rsp_ready = 4'b0000;
        req_addr  = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_stall();
        test_async_reset();
        test_idle();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
